// File: rtl/note_entry_pkg.sv
// Shared types and helpers for the note entry decoder: FSM encoding, key codes,
// and the letter/octave to MIDI arithmetic.
package note_entry_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LETTER = 2'd1,
        ST_SHARP  = 2'd2,
        ST_PUSH   = 2'd3
    } entry_state_e;

    localparam logic [7:0] ASCII_A   = 8'h41;
    localparam logic [7:0] ASCII_G   = 8'h47;
    localparam logic [7:0] ASCII_S   = 8'h53;
    localparam logic [7:0] ASCII_0   = 8'h30;
    localparam logic [7:0] ASCII_8   = 8'h38;
    localparam logic [7:0] ASCII_BS  = 8'h08;
    localparam logic [7:0] ASCII_ESC = 8'h1B;

    function automatic logic is_letter(input logic [7:0] c);
        return (c >= ASCII_A) && (c <= ASCII_G);
    endfunction

    function automatic logic is_digit(input logic [7:0] c);
        return (c >= ASCII_0) && (c <= ASCII_8);
    endfunction

    function automatic logic is_cancel(input logic [7:0] c);
        return (c == ASCII_BS) || (c == ASCII_ESC);
    endfunction

    function automatic logic [3:0] letter_semitone(input logic [7:0] c);
        logic [3:0] s;
        case (c)
            8'h41:   s = 4'd9;
            8'h42:   s = 4'd11;
            8'h43:   s = 4'd0;
            8'h44:   s = 4'd2;
            8'h45:   s = 4'd4;
            8'h46:   s = 4'd5;
            8'h47:   s = 4'd7;
            default: s = 4'd0;
        endcase
        return s;
    endfunction

    // Octave is at most 8, so the result tops out at 120 and fits in 7 bits.
    function automatic logic [6:0] calc_midi(input logic [3:0] octave,
                                             input logic [3:0] semitone,
                                             input logic       sharp);
        logic [6:0] base;
        base = 7'd12 * (7'(octave) + 7'd1);
        return base + 7'(semitone) + 7'(sharp);
    endfunction

endpackage

// File: rtl/note_entry_decoder_fifo.sv
// First-word-fall-through FIFO for completed MIDI notes; the output holds the
// last head once drained so downstream readers never see stale memory.
module note_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 7,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          wr_en,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_en,
    output logic [W-1:0]  rd_data,
    output logic          empty,
    output logic          full,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [W-1:0]  last_q, last_d;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign count   = count_q;
    assign do_pop  = rd_en & ~empty;
    // A write into a full FIFO still lands when the head leaves in the same cycle.
    assign do_push = wr_en & (~full | do_pop);
    assign rd_data = empty ? last_q : mem[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        last_d   = last_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (!empty) last_d = mem[rd_ptr_q];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            last_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            last_q   <= last_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/note_entry_decoder.sv
// Turns PS/2 key presses (letter, optional 'S', octave digit) into MIDI note
// numbers and queues them for the answer checker.
//
//   state     | meaning
//   ----------+----------------------------------------------------------
//   ST_IDLE   | no entry in progress, waiting for a note letter
//   ST_LETTER | letter latched, waiting for 'S', octave, new letter, cancel
//   ST_SHARP  | letter plus sharp latched, waiting for octave
//   ST_PUSH   | one cycle: completed note is written into the FIFO
module note_entry_decoder
    import note_entry_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 200000000,
    parameter int TO_W           = 28
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          new_key,
    input  logic [7:0]                    key_ascii,
    output logic                          note_valid,
    input  logic                          note_ready,
    output logic [6:0]                    note_midi,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          entry_busy,
    output logic                          bad_key,
    output logic                          overflow,
    input  logic                          clr_overflow
);

    localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT_CYCLES - 1);

    entry_state_e    state_q, state_d;
    logic [3:0]      semitone_q, semitone_d;
    logic            sharp_q, sharp_d;
    logic [3:0]      octave_q, octave_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            bad_key_q, bad_key_d;
    logic            overflow_q, overflow_d;

    logic            k_letter, k_digit, k_sharp, k_cancel;
    logic            fifo_wr, fifo_empty, fifo_full, ovf_set;
    logic [6:0]      fifo_wdata;

    assign k_letter = is_letter(key_ascii);
    assign k_digit  = is_digit(key_ascii);
    assign k_sharp  = (key_ascii == ASCII_S);
    assign k_cancel = is_cancel(key_ascii);

    assign fifo_wr    = (state_q == ST_PUSH);
    assign fifo_wdata = calc_midi(octave_q, semitone_q, sharp_q);
    assign ovf_set    = fifo_wr & fifo_full & ~(note_valid & note_ready);

    always_comb begin
        state_d    = state_q;
        semitone_d = semitone_q;
        sharp_d    = sharp_q;
        octave_d   = octave_q;
        to_cnt_d   = to_cnt_q;
        bad_key_d  = 1'b0;

        if (new_key && state_q != ST_PUSH) begin
            to_cnt_d = TO_LOAD;
        end else if ((state_q == ST_LETTER || state_q == ST_SHARP) && to_cnt_q != '0) begin
            to_cnt_d = to_cnt_q - TO_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (new_key) begin
                    if (k_letter) begin
                        state_d    = ST_LETTER;
                        semitone_d = letter_semitone(key_ascii);
                        sharp_d    = 1'b0;
                    end else if (!k_cancel) begin
                        bad_key_d = 1'b1;
                    end
                end
            end
            ST_LETTER, ST_SHARP: begin
                if (new_key) begin
                    if (k_letter) begin
                        state_d    = ST_LETTER;
                        semitone_d = letter_semitone(key_ascii);
                        sharp_d    = 1'b0;
                    end else if (k_digit) begin
                        state_d  = ST_PUSH;
                        octave_d = key_ascii[3:0];
                    end else if (k_cancel) begin
                        state_d = ST_IDLE;
                    end else if (k_sharp && state_q == ST_LETTER) begin
                        state_d = ST_SHARP;
                        sharp_d = 1'b1;
                    end else begin
                        bad_key_d = 1'b1;
                    end
                end else if (to_cnt_q == '0) begin
                    state_d = ST_IDLE;
                end
            end
            ST_PUSH: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (ovf_set)           overflow_d = 1'b1;
        else if (clr_overflow) overflow_d = 1'b0;
        else                   overflow_d = overflow_q;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            semitone_q <= '0;
            sharp_q    <= 1'b0;
            octave_q   <= '0;
            to_cnt_q   <= '0;
            bad_key_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            semitone_q <= semitone_d;
            sharp_q    <= sharp_d;
            octave_q   <= octave_d;
            to_cnt_q   <= to_cnt_d;
            bad_key_q  <= bad_key_d;
            overflow_q <= overflow_d;
        end
    end

    note_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (7)
    ) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .wr_en   (fifo_wr),
        .wr_data (fifo_wdata),
        .rd_en   (note_ready),
        .rd_data (note_midi),
        .empty   (fifo_empty),
        .full    (fifo_full),
        .count   (fifo_count)
    );

    assign note_valid = ~fifo_empty;
    assign entry_busy = (state_q != ST_IDLE);
    assign bad_key    = bad_key_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_note_entry_decoder.sv
// Randomised and directed bench for note_entry_decoder: a note-level reference
// model fills a scoreboard queue, a negedge monitor pops and compares.
module tb_note_entry_decoder;

    localparam int DEPTH = 8;
    localparam int TO    = 100;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       new_key = 1'b0;
    logic [7:0] key_ascii = 8'h00;
    logic       note_ready = 1'b0;
    logic       clr_overflow = 1'b0;
    logic       note_valid;
    logic [6:0] note_midi;
    logic [3:0] fifo_count;
    logic       entry_busy;
    logic       bad_key;
    logic       overflow;

    always #5 clk = ~clk;

    note_entry_decoder #(
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TO),
        .TO_W           (8)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .new_key      (new_key),
        .key_ascii    (key_ascii),
        .note_valid   (note_valid),
        .note_ready   (note_ready),
        .note_midi    (note_midi),
        .fifo_count   (fifo_count),
        .entry_busy   (entry_busy),
        .bad_key      (bad_key),
        .overflow     (overflow),
        .clr_overflow (clr_overflow)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: an entry is the text typed so far (none, letter, letter+S).
    int exp_q[$];
    int m_len = 0, m_semi = 0, m_pend = 0, m_pend_midi = 0, m_idle = 0, m_last = 0;
    int m_bad = 0, m_ovf = 0, m_c = 0;
    bit m_set_ovf;

    function automatic int semi_of(input int c);
        int tbl[7] = '{9, 11, 0, 2, 4, 5, 7};
        return tbl[c - 'h41];
    endfunction

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            exp_q.delete();
            m_len = 0; m_pend = 0; m_idle = 0; m_last = 0; m_bad = 0; m_ovf = 0;
        end else begin
            m_set_ovf = 1'b0;
            if (m_pend != 0) begin
                if (exp_q.size() < DEPTH) exp_q.push_back(m_pend_midi);
                else m_set_ovf = 1'b1;
            end
            if (m_set_ovf) m_ovf = 1;
            else if (clr_overflow) m_ovf = 0;
            m_bad = 0;
            if (m_pend != 0) begin
                m_pend = 0;
            end else if (new_key) begin
                m_c = int'(key_ascii);
                m_idle = 0;
                if (m_c == 'h08 || m_c == 'h1B) m_len = 0;
                else if (m_c >= 'h41 && m_c <= 'h47) begin
                    m_len = 1;
                    m_semi = semi_of(m_c);
                end else if (m_c == 'h53 && m_len == 1) m_len = 2;
                else if (m_c >= 'h30 && m_c <= 'h38 && m_len > 0) begin
                    m_pend = 1;
                    m_pend_midi = 12 * (m_c - 'h30 + 1) + m_semi + (m_len == 2 ? 1 : 0);
                    m_len = 0;
                end else m_bad = 1;
            end else if (m_len > 0) begin
                m_idle++;
                if (m_idle >= TO) m_len = 0;
            end
        end
    end

    always @(negedge clk) begin
        chk("note_valid", int'(note_valid), (exp_q.size() > 0) ? 1 : 0);
        chk("fifo_count", int'(fifo_count), exp_q.size());
        chk("note_midi", int'(note_midi), (exp_q.size() > 0) ? exp_q[0] : m_last);
        chk("entry_busy", int'(entry_busy), (m_len > 0 || m_pend != 0) ? 1 : 0);
        chk("bad_key", int'(bad_key), m_bad);
        chk("overflow", int'(overflow), m_ovf);
        if (exp_q.size() > 0 && note_ready) m_last = exp_q.pop_front();
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic key(input logic [7:0] c);
        new_key = 1'b1;
        key_ascii = c;
        tick();
        new_key = 1'b0;
        key_ascii = 8'($urandom);
    endtask

    task automatic keyg(input logic [7:0] c);
        key(c);
        tick();
    endtask

    task automatic pop_one();
        note_ready = 1'b1;
        tick();
        note_ready = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_valid"}, int'(note_valid), 0);
        chk({tag, "_midi"}, int'(note_midi), 0);
        chk({tag, "_count"}, int'(fifo_count), 0);
        chk({tag, "_busy"}, int'(entry_busy), 0);
        chk({tag, "_bad"}, int'(bad_key), 0);
        chk({tag, "_ovf"}, int'(overflow), 0);
    endtask

    logic [7:0] rk;
    int r;

    initial begin
        repeat (3) tick();
        chk_reset_vals("rst");
        resetn = 1'b1;
        tick();

        // A4 -> 69, visible two edges after the digit pulse
        keyg("A");
        key("4");
        chk("a4_valid_early", int'(note_valid), 0);
        tick();
        chk("a4_valid", int'(note_valid), 1);
        chk("a4_midi", int'(note_midi), 69);
        chk("a4_count", int'(fifo_count), 1);
        pop_one();
        chk("a4_popped", int'(fifo_count), 0);

        keyg("C"); keyg("S"); keyg("8");
        keyg("B"); keyg("S"); keyg("8");
        keyg("C"); keyg("0");
        tick();
        chk("order_count", int'(fifo_count), 3);
        chk("cs8_midi", int'(note_midi), 109);
        pop_one();
        chk("bs8_midi", int'(note_midi), 120);
        pop_one();
        chk("c0_midi", int'(note_midi), 12);
        pop_one();
        chk("order_drained", int'(fifo_count), 0);

        key("X");
        chk("x_bad", int'(bad_key), 1);
        tick();
        chk("x_bad_clear", int'(bad_key), 0);
        chk("x_no_entry", int'(fifo_count), 0);

        keyg("G"); keyg("E"); key("3");
        tick();
        chk("ge3_midi", int'(note_midi), 52);
        pop_one();

        keyg("D"); keyg(8'h1B); key("5");
        chk("esc_bad", int'(bad_key), 1);
        tick();
        chk("esc_no_entry", int'(fifo_count), 0);

        key("F");
        repeat (TO - 1) tick();
        chk("to_busy_before", int'(entry_busy), 1);
        tick();
        chk("to_busy_after", int'(entry_busy), 0);
        key("4");
        chk("to_bad", int'(bad_key), 1);
        tick();

        for (int i = 0; i < 9; i++) begin
            keyg(8'(8'h41 + i % 7));
            keyg(8'(8'h30 + i % 9));
        end
        tick();
        chk("full_count", int'(fifo_count), 8);
        chk("full_ovf", int'(overflow), 1);
        chk("full_head", int'(note_midi), 21);
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        chk("clr_ovf", int'(overflow), 0);
        keyg("C");
        key("5");
        note_ready = 1'b1;
        tick();
        note_ready = 1'b0;
        chk("pushpop_count", int'(fifo_count), 8);
        chk("pushpop_ovf", int'(overflow), 0);
        note_ready = 1'b1;
        repeat (10) tick();
        note_ready = 1'b0;
        chk("drain_count", int'(fifo_count), 0);
        chk("drain_hold_midi", int'(note_midi), 72);

        keyg("E"); key("2"); tick();
        keyg("A");
        resetn = 1'b0;
        #1;
        chk_reset_vals("midrst");
        tick();
        resetn = 1'b1;
        tick();
        key("4");
        chk("midrst_bad", int'(bad_key), 1);
        tick();

        for (int i = 0; i < 4000; i++) begin
            new_key = (i < 2500) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 40) == 0);
            r = $urandom_range(0, 9);
            if (r <= 3)      rk = 8'(8'h41 + $urandom_range(0, 6));
            else if (r == 4) rk = 8'h53;
            else if (r <= 7) rk = 8'(8'h30 + $urandom_range(0, 9));
            else if (r == 8) rk = ($urandom_range(0, 1) == 0) ? 8'h08 : 8'h1B;
            else             rk = 8'($urandom);
            key_ascii = rk;
            note_ready = (i < 1500) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 1) == 0);
            clr_overflow = ($urandom_range(0, 60) == 0);
            tick();
        end
        new_key = 1'b0;
        clr_overflow = 1'b0;
        note_ready = 1'b1;
        repeat (20) tick();
        chk("final_drained", int'(fifo_count), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
